pa_soc_itcm_arb: RTL and testbench



---
 rtl/pa_soc_itcm_arb.sv | 87 ++++++++
 tb/tb_pa_soc_itcm_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pa_soc_itcm_arb.sv
// Two-port read arbiter in front of the single-port ITCM: load/store has priority,
// with a starvation guard that forces a fetch win after STARVE_MAX lost conflicts.
module pa_soc_itcm_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_err_o,
  output logic [ADDR_W-1:0] itcm_addr_o,
  input  logic [DATA_W-1:0] itcm_data_i,
  input  logic              itcm_unalign_i
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              if_gnt, ls_gnt, force_if;
  logic [DATA_W-1:0] rsp_data;

  logic              if_rvalid_q, ls_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              if_err_q, ls_err_q;

  always_comb begin
    force_if    = if_req_i && (starve_q == StarveMax);
    ls_gnt      = !rst_i && ls_req_i && !force_if;
    if_gnt      = !rst_i && if_req_i && !ls_gnt;
    itcm_addr_o = ls_gnt ? ls_addr_i : if_addr_i;
    // Misaligned reads return zero data alongside the error flag.
    rsp_data    = itcm_unalign_i ? '0 : itcm_data_i;

    starve_d = starve_q;
    if (!if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (ls_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_gnt;
      ls_rvalid_q <= ls_gnt;
      // Only the owning port's response registers update; the other holds.
      if (if_gnt) begin
        if_rdata_q <= rsp_data;
        if_err_q   <= itcm_unalign_i;
      end
      if (ls_gnt) begin
        ls_rdata_q <= rsp_data;
        ls_err_q   <= itcm_unalign_i;
      end
    end
  end

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign if_err_o    = if_err_q;
  assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_pa_soc_itcm_arb.sv
// Scoreboard bench for pa_soc_itcm_arb: directed scenarios plus random traffic checked
// against a reference model of the grant rules and a simple ITCM memory model.
module tb_pa_soc_itcm_arb;

  localparam int unsigned StarveMax = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err;
  logic [31:0] if_rdata, ls_rdata, itcm_addr, itcm_data;
  logic        itcm_unalign;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ITCM model: combinational read, misaligned unless word aligned.
  assign itcm_data    = mem(itcm_addr);
  assign itcm_unalign = |itcm_addr[1:0];

  pa_soc_itcm_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(StarveMax)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_gnt_o       (if_gnt),
    .if_rvalid_o    (if_rvalid),
    .if_rdata_o     (if_rdata),
    .if_err_o       (if_err),
    .ls_req_i       (ls_req),
    .ls_addr_i      (ls_addr),
    .ls_gnt_o       (ls_gnt),
    .ls_rvalid_o    (ls_rvalid),
    .ls_rdata_o     (ls_rdata),
    .ls_err_o       (ls_err),
    .itcm_addr_o    (itcm_addr),
    .itcm_data_i    (itcm_data),
    .itcm_unalign_i (itcm_unalign)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[2][$];  // 0: fetch, 1: load/store
  logic [31:0] last_d[2];
  logic        last_e[2];
  int unsigned cycle = 0;
  int unsigned lost = 0;     // consecutive conflicts fetch has lost
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  function automatic rsp_t expect_rsp(input logic [31:0] a);
    rsp_t r;
    r.cyc  = cycle + 1;
    r.err  = (a[1:0] != 2'b00);
    r.data = r.err ? 32'h0 : mem(a);
    return r;
  endfunction

  // Drive one cycle of requests, check grants against the model, queue expected responses.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr,
                      input logic [31:0] la, output logic gi, output logic gl);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
    @(negedge clk);
    gl = lr && !(ir && (lost == StarveMax));
    gi = ir && !gl;
    check("ls_gnt", {31'b0, ls_gnt}, {31'b0, gl});
    check("if_gnt", {31'b0, if_gnt}, {31'b0, gi});
    check("itcm_addr", itcm_addr, gl ? la : ia);
    if (gi) exp_q[0].push_back(expect_rsp(ia));
    if (gl) exp_q[1].push_back(expect_rsp(la));
    if (ir && gl) lost = (lost < StarveMax) ? lost + 1 : lost;
    else          lost = 0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_q[p].delete();
      last_d[p] = '0;
      last_e[p] = 1'b0;
    end
    lost = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
      check("rst_ls_gnt", {31'b0, ls_gnt}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
    rsp_t  e;
    string nm;
    nm = (p == 0) ? "if" : "ls";
    if (rv) begin
      if (exp_q[p].size() == 0) begin
        check({nm, "_rvalid_spurious"}, 32'h1, 32'h0);
      end else begin
        e = exp_q[p].pop_front();
        check({nm, "_rvalid_cycle"}, cycle, e.cyc);
        last_d[p] = e.data;
        last_e[p] = e.err;
      end
    end else if (exp_q[p].size() > 0 && exp_q[p][0].cyc <= cycle) begin
      e = exp_q[p].pop_front();
      check({nm, "_rvalid_missing"}, 32'h0, 32'h1);
    end
    // rdata/err must show the latest response of this port, held between pulses.
    check({nm, "_rdata"}, rd, last_d[p]);
    check({nm, "_err"}, {31'b0, er}, {31'b0, last_e[p]});
  endtask

  always @(negedge clk) begin
    mon_port(0, if_rvalid, if_rdata, if_err);
    mon_port(1, ls_rvalid, ls_rdata, ls_err);
  end

  initial begin
    logic        gi, gl, pi, pl;
    logic [31:0] ai, al;
    int unsigned wait_if;
    for (int p = 0; p < 2; p++) begin
      last_d[p] = '0;
      last_e[p] = 1'b0;
    end
    do_reset(2);

    // Fetch only, aligned.
    step(1, 32'h0000_0010, 0, 32'h0, gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);

    // Both requesting continuously: 4 ls wins, forced fetch, then ls again.
    for (int i = 0; i < 12; i++) step(1, 32'h0000_0100, 1, 32'h0000_2000 + 32'(4 * i), gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);

    // Misaligned ls access.
    step(0, 32'h0, 1, 32'h0000_0102, gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);

    // Alternating ls, if, ls.
    step(0, 32'h0, 1, 32'h0000_0300, gi, gl);
    step(1, 32'h0000_0404, 0, 32'h0, gi, gl);
    step(0, 32'h0, 1, 32'h0000_0508, gi, gl);

    // Reset the cycle after a fetch grant; the pending response must vanish.
    step(1, 32'h0000_0600, 0, 32'h0, gi, gl);
    do_reset(1);
    step(1, 32'h0000_0700, 1, 32'h0000_0800, gi, gl);
    step(1, 32'h0000_0700, 0, 32'h0, gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);

    // Fetch drops after two lost conflicts, counter restarts from zero.
    step(1, 32'h0000_0900, 1, 32'h0000_0A00, gi, gl);
    step(1, 32'h0000_0900, 1, 32'h0000_0A04, gi, gl);
    step(0, 32'h0, 1, 32'h0000_0A08, gi, gl);
    for (int i = 0; i < 6; i++) step(1, 32'h0000_0904, 1, 32'h0000_0B00 + 32'(4 * i), gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);

    // Random traffic; each requester holds its request until granted.
    pi = 0; pl = 0; ai = '0; al = '0; wait_if = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pi && ($urandom_range(0, 3) != 0)) begin
        pi = 1;
        ai = {$urandom_range(0, 32'hFFFF), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0);
      end
      if (!pl && ($urandom_range(0, 3) != 0)) begin
        pl = 1;
        al = {$urandom_range(0, 32'hFFFF), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
      end
      step(pi, ai, pl, al, gi, gl);
      if (pi && !gi) wait_if++;
      if (gi) begin
        check("if_stall_bound", {31'b0, wait_if <= StarveMax}, 32'h1);
        wait_if = 0;
        pi = 0;
      end
      if (gl) pl = 0;
    end
    step(0, 32'h0, 0, 32'h0, gi, gl);
    step(0, 32'h0, 0, 32'h0, gi, gl);
    @(negedge clk);
    check("if_queue_drained", exp_q[0].size(), 32'h0);
    check("ls_queue_drained", exp_q[1].size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
